// File: rtl/rv32_pkg.sv
// Shared opcode classes and FSM encoding for the RV32 branch resolution controller.
package rv32_pkg;

    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    function automatic logic is_ctrl_xfer(input logic [4:0] opc);
        return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/rv32_sat_counter.sv
// Saturating up-counter used for branch/mispredict statistics; sticks at all-ones.
module rv32_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             inc_in,
    output logic [WIDTH-1:0] count_out
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_out <= '0;
        end else if (inc_in && (count_out != '1)) begin
            count_out <= count_out + ONE;
        end
    end

endmodule

// File: rtl/rv32_branch_ctrl.sv
// EX-stage branch resolution: detects mispredicts, flushes IF/ID, then redirects fetch.
// Statistics counters are built only when RV32_BRANCH_STATS_EN is defined.
module rv32_branch_ctrl
    import rv32_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 ex_valid_in,
    input  logic [4:0]           opcode_6_to_2_in,
    input  logic                 branch_taken_in,
    input  logic                 predicted_taken_in,
    input  logic [31:0]          target_in,
    input  logic [31:0]          pc_plus4_in,
    input  logic                 fetch_ready_in,
    output logic                 flush_out,
    output logic                 stall_out,
    output logic                 redirect_valid_out,
    output logic [31:0]          redirect_pc_out,
    output logic [CNT_WIDTH-1:0] branch_count_out,
    output logic [CNT_WIDTH-1:0] mispredict_count_out
);

    logic        w_is_branch;
    logic        w_is_jal;
    logic        w_is_jalr;
    logic        w_accept;
    logic        w_actual_taken;
    logic        w_mispredict;
    logic [31:0] w_next_pc;

    state_t      r_state;
    logic        r_flush;
    logic        r_stall;
    logic        r_redir_valid;
    logic [31:0] r_redir_pc;
    logic [31:0] r_pc_latch;

    always_comb begin
        w_is_branch    = (opcode_6_to_2_in == OPC_BRANCH);
        w_is_jal       = (opcode_6_to_2_in == OPC_JAL);
        w_is_jalr      = (opcode_6_to_2_in == OPC_JALR);
        // Only an idle controller looks at EX; anything arriving mid-recovery is dropped.
        w_accept       = ex_valid_in && (r_state == ST_IDLE) && is_ctrl_xfer(opcode_6_to_2_in);
        w_actual_taken = w_is_branch ? branch_taken_in : 1'b1;
        w_mispredict   = 1'b0;
        if (w_is_branch) w_mispredict = (branch_taken_in != predicted_taken_in);
        if (w_is_jal)    w_mispredict = !predicted_taken_in;
        if (w_is_jalr)   w_mispredict = 1'b1;
        w_next_pc = pc_plus4_in;
        if (w_actual_taken) w_next_pc = w_is_jalr ? {target_in[31:1], 1'b0} : target_in;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state       <= ST_IDLE;
            r_flush       <= 1'b0;
            r_stall       <= 1'b0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
            r_pc_latch    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_mispredict) begin
                        r_pc_latch <= w_next_pc;
                        r_flush    <= 1'b1;
                        r_stall    <= 1'b1;
                        r_state    <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    r_flush       <= 1'b0;
                    r_redir_valid <= 1'b1;
                    r_redir_pc    <= r_pc_latch;
                    r_state       <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    // Redirect PC is zeroed on exit so it reads 0 whenever not valid.
                    if (fetch_ready_in) begin
                        r_redir_valid <= 1'b0;
                        r_redir_pc    <= '0;
                        r_stall       <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_flush       <= 1'b0;
                    r_stall       <= 1'b0;
                    r_redir_valid <= 1'b0;
                    r_redir_pc    <= '0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign flush_out          = r_flush;
    assign stall_out          = r_stall;
    assign redirect_valid_out = r_redir_valid;
    assign redirect_pc_out    = r_redir_pc;

`ifdef RV32_BRANCH_STATS_EN
    logic w_mis_inc;
    assign w_mis_inc = w_accept && w_mispredict;

    rv32_sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .inc_in    (w_accept),
        .count_out (branch_count_out)
    );

    rv32_sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .inc_in    (w_mis_inc),
        .count_out (mispredict_count_out)
    );
`else
    assign branch_count_out     = '0;
    assign mispredict_count_out = '0;
`endif

endmodule

// File: tb/tb_rv32_branch_ctrl.sv
// Bench for rv32_branch_ctrl: directed vector table, hand sequences and a random run vs a reference model.
module tb_rv32_branch_ctrl;

    localparam int CW = 4;
    localparam logic [4:0] BR = 5'b11000, JAL = 5'b11011, JALR = 5'b11001, ALU = 5'b01100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          v = 1'b0, tk = 1'b0, pr = 1'b0, rdy = 1'b0;
    logic [4:0]    op = '0;
    logic [31:0]   tg = '0, p4 = '0;
    logic          fl, st, rv;
    logic [31:0]   rpc;
    logic [CW-1:0] bc, mc;

    int checks = 0;
    int errors = 0;

    // reference model: cycles elapsed since the accepted mispredict (-1 = nothing pending)
    int          m_since = -1;
    logic [31:0] m_pc = '0;
    int          m_bc = 0, m_mc = 0;

    rv32_branch_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk_in               (clk),
        .rst_in               (rst),
        .ex_valid_in          (v),
        .opcode_6_to_2_in     (op),
        .branch_taken_in      (tk),
        .predicted_taken_in   (pr),
        .target_in            (tg),
        .pc_plus4_in          (p4),
        .fetch_ready_in       (rdy),
        .flush_out            (fl),
        .stall_out            (st),
        .redirect_valid_out   (rv),
        .redirect_pc_out      (rpc),
        .branch_count_out     (bc),
        .mispredict_count_out (mc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v; logic [4:0] op; logic tk, pr; logic [31:0] tg, p4; logic rdy;
        logic e_fl, e_st, e_rv; logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(logic v_, logic [4:0] op_, logic tk_, logic pr_, logic [31:0] tg_,
                                logic [31:0] p4_, logic rdy_, logic efl, logic est, logic erv,
                                logic [31:0] epc);
        vec_t r;
        r.v = v_; r.op = op_; r.tk = tk_; r.pr = pr_; r.tg = tg_; r.p4 = p4_; r.rdy = rdy_;
        r.e_fl = efl; r.e_st = est; r.e_rv = erv; r.e_pc = epc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_ctrl(logic [4:0] o);
        return (o == BR) || (o == JAL) || (o == JALR);
    endfunction

    // model update for one rising edge, from the rules as written
    task automatic model_edge();
        logic mis, taken;
        if (m_since < 0) begin
            if (v && is_ctrl(op)) begin
                taken = (op == BR) ? tk : 1'b1;
                mis = (op == JALR) || (op == JAL && !pr) || (op == BR && tk != pr);
`ifdef RV32_BRANCH_STATS_EN
                if (m_bc < (1 << CW) - 1) m_bc++;
                if (mis && m_mc < (1 << CW) - 1) m_mc++;
`endif
                if (mis) begin
                    m_since = 1;
                    m_pc = !taken ? p4 : (op == JALR) ? (tg & 32'hFFFF_FFFE) : tg;
                end
            end
        end else if (m_since == 1) begin
            m_since = 2;
        end else if (rdy) begin
            m_since = -1;
        end else begin
            m_since = m_since + 1;
        end
    endtask

    task automatic model_reset();
        m_since = -1; m_pc = '0; m_bc = 0; m_mc = 0;
    endtask

    task automatic chk_model();
        chk("m_flush", 32'(fl), 32'(m_since == 1));
        chk("m_stall", 32'(st), 32'(m_since >= 1));
        chk("m_rvalid", 32'(rv), 32'(m_since >= 2));
        chk("m_rpc", rpc, (m_since >= 2) ? m_pc : 32'h0);
        chk("m_bcount", 32'(bc), 32'(m_bc));
        chk("m_mcount", 32'(mc), 32'(m_mc));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk_model();
    endtask

    task automatic drive(logic v_, logic [4:0] op_, logic tk_, logic pr_, logic [31:0] tg_,
                         logic [31:0] p4_, logic rdy_);
        v = v_; op = op_; tk = tk_; pr = pr_; tg = tg_; p4 = p4_; rdy = rdy_;
    endtask

    vec_t tbl[17];

    initial begin
        tbl[0]  = mk(1, BR,   1, 0, 32'h1000, 32'h0804, 0, 1, 1, 0, 32'h0);
        tbl[1]  = mk(0, BR,   0, 0, 32'h0,    32'h0,    1, 0, 1, 1, 32'h1000);
        tbl[2]  = mk(0, BR,   0, 0, 32'h0,    32'h0,    0, 0, 1, 1, 32'h1000);
        tbl[3]  = mk(0, BR,   0, 0, 32'h0,    32'h0,    1, 0, 0, 0, 32'h0);
        tbl[4]  = mk(1, BR,   0, 1, 32'h5000, 32'h2004, 0, 1, 1, 0, 32'h0);
        tbl[5]  = mk(0, BR,   0, 0, 32'h0,    32'h0,    0, 0, 1, 1, 32'h2004);
        tbl[6]  = mk(0, BR,   0, 0, 32'h0,    32'h0,    1, 0, 0, 0, 32'h0);
        tbl[7]  = mk(1, BR,   1, 1, 32'h6000, 32'h0100, 0, 0, 0, 0, 32'h0);
        tbl[8]  = mk(1, BR,   0, 0, 32'h6000, 32'h0100, 0, 0, 0, 0, 32'h0);
        tbl[9]  = mk(1, JALR, 0, 1, 32'h3003, 32'h0100, 0, 1, 1, 0, 32'h0);
        tbl[10] = mk(0, BR,   0, 0, 32'h0,    32'h0,    1, 0, 1, 1, 32'h3002);
        tbl[11] = mk(0, BR,   0, 0, 32'h0,    32'h0,    1, 0, 0, 0, 32'h0);
        tbl[12] = mk(1, JAL,  0, 1, 32'h7000, 32'h0100, 0, 0, 0, 0, 32'h0);
        tbl[13] = mk(1, JAL,  0, 0, 32'h4000, 32'h0100, 0, 1, 1, 0, 32'h0);
        tbl[14] = mk(0, BR,   0, 0, 32'h0,    32'h0,    0, 0, 1, 1, 32'h4000);
        tbl[15] = mk(0, BR,   0, 0, 32'h0,    32'h0,    1, 0, 0, 0, 32'h0);
        tbl[16] = mk(1, ALU,  0, 1, 32'h8000, 32'h0100, 0, 0, 0, 0, 32'h0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flush", 32'(fl), 32'h0);
        chk("rst_stall", 32'(st), 32'h0);
        chk("rst_rvalid", 32'(rv), 32'h0);
        chk("rst_rpc", rpc, 32'h0);
        chk("rst_counts", 32'({bc, mc}), 32'h0);
        @(negedge clk) rst = 1'b0;

        // directed table
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].tk, tbl[i].pr, tbl[i].tg, tbl[i].p4, tbl[i].rdy);
            step();
            chk($sformatf("vec%0d_flush", i), 32'(fl), 32'(tbl[i].e_fl));
            chk($sformatf("vec%0d_stall", i), 32'(st), 32'(tbl[i].e_st));
            chk($sformatf("vec%0d_rvalid", i), 32'(rv), 32'(tbl[i].e_rv));
            chk($sformatf("vec%0d_rpc", i), rpc, tbl[i].e_pc);
        end

        // redirect held 5 cycles with fetch not ready; mispredicts meanwhile are dropped
        drive(1, BR, 1, 0, 32'h0000_A000, 32'h0000_0200, 0);
        step();
        drive(0, BR, 0, 0, 32'h0, 32'h0, 0);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(1, JALR, 0, 1, 32'h0000_B001 + 32'(k), 32'h0000_0300, 0);
            step();
            chk("hold_rvalid", 32'(rv), 32'h1);
            chk("hold_rpc", rpc, 32'h0000_A000);
            chk("hold_flush", 32'(fl), 32'h0);
        end
        drive(0, BR, 0, 0, 32'h0, 32'h0, 1);
        step();
        chk("hold_exit", 32'({fl, st, rv}), 32'h0);
        step();
        chk("no_queue", 32'({fl, st, rv}), 32'h0);

        // asynchronous reset in the middle of a redirect
        drive(1, JALR, 0, 0, 32'h0000_C005, 32'h0000_0400, 0);
        step();
        drive(0, BR, 0, 0, 32'h0, 32'h0, 0);
        step();
        chk("pre_rst_rvalid", 32'(rv), 32'h1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("arst_flush", 32'(fl), 32'h0);
        chk("arst_stall", 32'(st), 32'h0);
        chk("arst_rvalid", 32'(rv), 32'h0);
        chk("arst_rpc", rpc, 32'h0);
        chk("arst_bcount", 32'(bc), 32'h0);
        chk("arst_mcount", 32'(mc), 32'h0);
        @(negedge clk) rst = 1'b0;
        step();
        drive(1, BR, 0, 1, 32'h0, 32'h0000_0504, 1);
        step();
        chk("post_rst_flush", 32'(fl), 32'h1);

        // 20 mispredicts saturate the 4-bit counter
        @(negedge clk) rst = 1'b1;
        model_reset();
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive(1, JALR, 0, 1, 32'h0000_1000 + 32'(k * 4), 32'h0, 1);
            step();
            drive(0, BR, 0, 0, 32'h0, 32'h0, 1);
            step();
            step();
        end
`ifdef RV32_BRANCH_STATS_EN
        chk("sat_mcount", 32'(mc), 32'hF);
        chk("sat_bcount", 32'(bc), 32'hF);
`else
        chk("off_mcount", 32'(mc), 32'h0);
        chk("off_bcount", 32'(bc), 32'h0);
`endif

        // randomized run against the model
        for (int k = 0; k < 400; k++) begin
            logic [4:0] o;
            case ($urandom_range(0, 3))
                0: o = BR;
                1: o = JAL;
                2: o = JALR;
                default: o = 5'($urandom_range(0, 31));
            endcase
            drive(1'($urandom_range(0, 1)), o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, ($urandom_range(0, 3) != 0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32_branch_ctrl.md
RV32_BRANCH_CTRL -- requirements
Module: rv32_branch_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 16, setting the width of each statistics counter.
REQ-002 The block SHALL have port clk_in, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_in, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port ex_valid_in, input, 1 bit: a control-transfer instruction is resolved in EX this cycle.
REQ-005 The block SHALL have port opcode_6_to_2_in, input, 5 bits: instr[6:2] of the EX instruction.
REQ-006 The block SHALL have port branch_taken_in, input, 1 bit: resolved taken flag from the branch unit.
REQ-007 The block SHALL have port predicted_taken_in, input, 1 bit: the fetch-time prediction carried with the instruction.
REQ-008 The block SHALL have port target_in, input, 32 bits: computed branch/jump target.
REQ-009 The block SHALL have port pc_plus4_in, input, 32 bits: fall-through PC of the EX instruction.
REQ-010 The block SHALL have port fetch_ready_in, input, 1 bit: fetch accepts the redirect.
REQ-011 The block SHALL have port flush_out, output, 1 bit: kill IF/ID contents.
REQ-012 The block SHALL have port stall_out, output, 1 bit: hold EX and earlier stages.
REQ-013 The block SHALL have port redirect_valid_out, output, 1 bit: redirect request to fetch.
REQ-014 The block SHALL have port redirect_pc_out, output, 32 bits: new fetch PC.
REQ-015 The block SHALL have ports branch_count_out and mispredict_count_out, output, CNT_WIDTH bits each: statistics.

Function
REQ-016 Opcode classes SHALL be BRANCH=5'b11000, JAL=5'b11011, JALR=5'b11001; any other opcode with ex_valid_in SHALL be ignored.
REQ-017 Actual-taken SHALL be branch_taken_in for BRANCH and forced 1 for JAL/JALR.
REQ-018 Mispredict SHALL be: BRANCH with actual != predicted_taken_in; JAL with predicted_taken_in=0; JALR always.
REQ-019 FSM states SHALL be IDLE, FLUSH, REDIRECT.
REQ-020 In IDLE, a sampled mispredict SHALL latch redirect PC (target_in if actual-taken, else pc_plus4_in; JALR target with bit 0 cleared) and go to FLUSH.
REQ-021 FLUSH SHALL last exactly one cycle with flush_out=1, then go to REDIRECT unconditionally; fetch_ready_in is ignored in FLUSH.
REQ-022 REDIRECT SHALL hold redirect_valid_out=1 and a stable redirect_pc_out until a cycle with fetch_ready_in=1, then return to IDLE on that edge.
REQ-023 stall_out SHALL be 1 in FLUSH and REDIRECT, 0 in IDLE.
REQ-024 Latency: mispredict sampled at edge N SHALL give flush_out=1 in cycle N+1 and redirect_valid_out=1 from cycle N+2; minimum mispredict cost is 3 cycles.
REQ-025 ex_valid_in SHALL be ignored outside IDLE; no second mispredict is queued.
REQ-026 redirect_pc_out SHALL be 0 whenever redirect_valid_out is 0.
REQ-027 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 rst_in SHALL force state IDLE and all outputs, including counters and latched PC, to 0, at any point including mid-REDIRECT; the pending redirect is discarded.

Configuration
REQ-029 With RV32_BRANCH_STATS_EN defined, branch_count_out SHALL increment on every accepted valid BRANCH/JAL/JALR in IDLE and mispredict_count_out on every accepted mispredict, both saturating at all-ones.
REQ-030 Without RV32_BRANCH_STATS_EN, both counter ports SHALL remain and be driven constant 0, with no counter logic synthesized.

Structure
REQ-031 Opcode constants and the FSM state encoding SHALL live in shared package rv32_pkg.
REQ-032 The saturating counter SHALL be sub-module rv32_sat_counter (parameter WIDTH, ports clk_in, rst_in, inc_in, count_out), instantiated twice under the macro.

Verification
REQ-033 BRANCH, predicted 0, taken 1, target 0x0000_1000 -> flush_out in cycle N+1, redirect_valid_out with redirect_pc_out=0x0000_1000 from N+2, IDLE after fetch_ready_in.
REQ-034 BRANCH, predicted 1, taken 0, pc_plus4 0x0000_2004 -> redirect_pc_out=0x0000_2004; BRANCH with predicted == taken -> no flush, stall_out stays 0.
REQ-035 JALR target 0x0000_3003 -> redirect_pc_out=0x0000_3002; JAL predicted 1 -> no redirect.
REQ-036 fetch_ready_in low for 5 cycles in REDIRECT -> redirect_valid_out and redirect_pc_out stable for 5 cycles; a mispredicting ex_valid_in during that time is ignored.
REQ-037 rst_in asserted in REDIRECT -> all outputs 0 immediately, state IDLE; with RV32_BRANCH_STATS_EN, counters read 0.
REQ-038 With RV32_BRANCH_STATS_EN and CNT_WIDTH=4, 20 mispredicts -> mispredict_count_out=4'hF, saturated.
